// File: rtl/rrc_pkg.sv
// rtl/rrc_pkg.sv - shared RRC prototype taps, sizing constants and output rounding
package rrc_pkg;

    localparam int SUB_FILTER_TAPS = 11;
    localparam int NUM_TAPS        = 4 * SUB_FILTER_TAPS;
    localparam int DECIM           = 4;

    typedef enum logic [2:0] {
        IDLE,
        MAC0,
        MAC1,
        MAC2,
        MAC3
    } mf_state_e;

    // Symmetric 44-tap prototype; only the first half is stored and mirrored.
    function automatic logic signed [17:0] proto_tap(input logic [5:0] n);
        logic [5:0] m;
        m = (n < 6'd22) ? n : 6'd43 - n;
        case (m)
            6'd0:    return -18'sd150;
            6'd1:    return -18'sd260;
            6'd2:    return -18'sd220;
            6'd3:    return 18'sd0;
            6'd4:    return 18'sd330;
            6'd5:    return 18'sd540;
            6'd6:    return 18'sd460;
            6'd7:    return 18'sd0;
            6'd8:    return -18'sd700;
            6'd9:    return -18'sd1150;
            6'd10:   return -18'sd1000;
            6'd11:   return 18'sd0;
            6'd12:   return 18'sd1700;
            6'd13:   return 18'sd3400;
            6'd14:   return 18'sd3600;
            6'd15:   return 18'sd5200;
            6'd16:   return 18'sd9800;
            6'd17:   return 18'sd15400;
            6'd18:   return 18'sd21200;
            6'd19:   return 18'sd26600;
            6'd20:   return 18'sd30800;
            6'd21:   return 18'sd32700;
            default: return 18'sd0;
        endcase
    endfunction

    function automatic logic signed [17:0] get_coeff(input logic [1:0] phase, input int k);
        logic [5:0] n;
        n = 6'(k * 4) + {4'b0000, phase};
        return proto_tap(n);
    endfunction

    function automatic logic signed [15:0] round_sat16(input logic signed [63:0] acc);
        logic signed [63:0] r;
        r = (acc + 64'sd32768) >>> 16;
        if (r > 64'sd32767) begin
            return 16'sh7fff;
        end else if (r < -64'sd32768) begin
            return 16'sh8000;
        end else begin
            return r[15:0];
        end
    endfunction

endpackage

// File: rtl/rrc_mac_lane.sv
// rtl/rrc_mac_lane.sv - combinational 11-tap polyphase dot product for one rail
module rrc_mac_lane
    import rrc_pkg::*;
#(
    parameter int ACC_W = 48
) (
    input  logic        [1:0]       phase,
    input  logic signed [15:0]      taps [NUM_TAPS],
    output logic signed [ACC_W-1:0] partial
);

    logic        [5:0]  idx;
    logic signed [33:0] prod;

    always_comb begin
        partial = '0;
        idx     = '0;
        prod    = '0;
        for (int k = 0; k < SUB_FILTER_TAPS; k++) begin
            idx     = 6'(k * 4) + {4'b0000, phase};
            prod    = 34'(taps[idx]) * 34'(get_coeff(phase, k));
            partial = partial + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/rrc_matched_filter.sv
// rtl/rrc_matched_filter.sv - RRC matched filter with 4:1 decimation, one polyphase branch per cycle
module rrc_matched_filter
    import rrc_pkg::*;
#(
    parameter int ACC_W = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic signed [15:0] i_in,
    input  logic signed [15:0] q_in,
    input  logic        [1:0]  sym_phase,
    output logic               valid_out,
    output logic signed [15:0] i_out,
    output logic signed [15:0] q_out
);

    logic signed [15:0] win_i_q  [NUM_TAPS];
    logic signed [15:0] win_i_d  [NUM_TAPS];
    logic signed [15:0] win_q_q  [NUM_TAPS];
    logic signed [15:0] win_q_d  [NUM_TAPS];
    logic signed [15:0] snap_i_q [NUM_TAPS];
    logic signed [15:0] snap_i_d [NUM_TAPS];
    logic signed [15:0] snap_q_q [NUM_TAPS];
    logic signed [15:0] snap_q_d [NUM_TAPS];

    logic        [1:0]       cnt_q, cnt_d;
    mf_state_e               state_q, state_d;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic                    valid_out_q, valid_out_d;
    logic signed [15:0]      i_out_q, i_out_d, q_out_q, q_out_d;

    logic                    dec;
    logic        [1:0]       mac_phase;
    logic signed [ACC_W-1:0] partial_i, partial_q, sum_i, sum_q;

    assign dec       = valid_in && (cnt_q == sym_phase);
    assign valid_out = valid_out_q;
    assign i_out     = i_out_q;
    assign q_out     = q_out_q;

    always_comb begin
        case (state_q)
            MAC1:    mac_phase = 2'd1;
            MAC2:    mac_phase = 2'd2;
            MAC3:    mac_phase = 2'd3;
            default: mac_phase = 2'd0;
        endcase
    end

    rrc_mac_lane #(.ACC_W(ACC_W)) u_lane_i (
        .phase   (mac_phase),
        .taps    (snap_i_q),
        .partial (partial_i)
    );

    rrc_mac_lane #(.ACC_W(ACC_W)) u_lane_q (
        .phase   (mac_phase),
        .taps    (snap_q_q),
        .partial (partial_q)
    );

    always_comb begin
        win_i_d     = win_i_q;
        win_q_d     = win_q_q;
        snap_i_d    = snap_i_q;
        snap_q_d    = snap_q_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        valid_out_d = 1'b0;
        i_out_d     = i_out_q;
        q_out_d     = q_out_q;
        sum_i       = acc_i_q + partial_i;
        sum_q       = acc_q_q + partial_q;

        if (valid_in) begin
            win_i_d[0] = i_in;
            win_q_d[0] = q_in;
            for (int k = 1; k < NUM_TAPS; k++) begin
                win_i_d[k] = win_i_q[k-1];
                win_q_d[k] = win_q_q[k-1];
            end
            cnt_d = cnt_q + 2'd1;
        end

        case (state_q)
            MAC0: begin acc_i_d = sum_i; acc_q_d = sum_q; state_d = MAC1; end
            MAC1: begin acc_i_d = sum_i; acc_q_d = sum_q; state_d = MAC2; end
            MAC2: begin acc_i_d = sum_i; acc_q_d = sum_q; state_d = MAC3; end
            MAC3: begin
                i_out_d     = round_sat16(64'(sum_i));
                q_out_d     = round_sat16(64'(sum_q));
                valid_out_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new decimation point always wins: it finishes MAC3 above but aborts MAC0..MAC2.
        if (dec) begin
            snap_i_d = win_i_d;
            snap_q_d = win_q_d;
            acc_i_d  = '0;
            acc_q_d  = '0;
            state_d  = MAC0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                win_i_q[k]  <= '0;
                win_q_q[k]  <= '0;
                snap_i_q[k] <= '0;
                snap_q_q[k] <= '0;
            end
            cnt_q       <= '0;
            state_q     <= IDLE;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            valid_out_q <= 1'b0;
            i_out_q     <= '0;
            q_out_q     <= '0;
        end else begin
            win_i_q     <= win_i_d;
            win_q_q     <= win_q_d;
            snap_i_q    <= snap_i_d;
            snap_q_q    <= snap_q_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            valid_out_q <= valid_out_d;
            i_out_q     <= i_out_d;
            q_out_q     <= q_out_d;
        end
    end

endmodule

// File: tb/tb_rrc_matched_filter.sv
// tb/tb_rrc_matched_filter.sv - scoreboard bench for the RRC matched filter against a direct-convolution model
module tb_rrc_matched_filter;
    import rrc_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid_in = 1'b0;
    logic signed [15:0] i_in = '0;
    logic signed [15:0] q_in = '0;
    logic        [1:0]  sym_phase = '0;
    logic               valid_out;
    logic signed [15:0] i_out;
    logic signed [15:0] q_out;

    rrc_matched_filter #(.ACC_W(48)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .i_in      (i_in),
        .q_in      (q_in),
        .sym_phase (sym_phase),
        .valid_out (valid_out),
        .i_out     (i_out),
        .q_out     (q_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int due;
        int i;
        int q;
    } exp_t;

    exp_t exq[$];
    exp_t mon_e;

    int m_win_i [NUM_TAPS];
    int m_win_q [NUM_TAPS];
    int m_cnt;
    bit pend;
    int pend_edge, pend_i, pend_q;

    function automatic longint h(input int n);
        return longint'(get_coeff(2'(n % 4), n / 4));
    endfunction

    function automatic int ref_out(input longint s);
        longint r;
        r = (s + 32768) >>> 16;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    function automatic void model_clear();
        for (int n = 0; n < NUM_TAPS; n++) begin
            m_win_i[n] = 0;
            m_win_q[n] = 0;
        end
        m_cnt = 0;
        pend  = 1'b0;
        exq.delete();
    endfunction

    function automatic void model_edge(input bit v, input int si, input int sq, input int ph);
        int     e;
        longint acc_i, acc_q;
        e = cyc + 1;
        if (pend && e >= pend_edge + DECIM) begin
            exq.push_back('{due: e, i: pend_i, q: pend_q});
            pend = 1'b0;
        end
        if (v) begin
            for (int n = NUM_TAPS - 1; n > 0; n--) begin
                m_win_i[n] = m_win_i[n-1];
                m_win_q[n] = m_win_q[n-1];
            end
            m_win_i[0] = si;
            m_win_q[0] = sq;
            if (m_cnt == ph) begin
                acc_i = 0;
                acc_q = 0;
                for (int n = 0; n < NUM_TAPS; n++) begin
                    acc_i += longint'(m_win_i[n]) * h(n);
                    acc_q += longint'(m_win_q[n]) * h(n);
                end
                pend      = 1'b1;
                pend_edge = e;
                pend_i    = ref_out(acc_i);
                pend_q    = ref_out(acc_q);
            end
            m_cnt = (m_cnt + 1) % DECIM;
        end
    endfunction

    task automatic step(input bit v, input logic signed [15:0] si, input logic signed [15:0] sq,
                        input logic [1:0] ph);
        @(negedge clk);
        valid_in  = v;
        i_in      = si;
        q_in      = sq;
        sym_phase = ph;
        model_edge(v, int'(si), int'(sq), int'(ph));
    endtask

    task automatic drain(input int n);
        for (int c = 0; c < n; c++) step(1'b0, 16'sd0, 16'sd0, sym_phase);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        valid_in = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_valid_out", valid_out, 0);
        check("rst_i_out", i_out, 0);
        check("rst_q_out", q_out, 0);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_out) begin
                if (exq.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    mon_e = exq.pop_front();
                    check("pulse_cycle", cyc, mon_e.due);
                    check("i_out", i_out, mon_e.i);
                    check("q_out", q_out, mon_e.q);
                end
            end
            while (exq.size() > 0 && exq[0].due < cyc) begin
                check("missing_pulse", 0, exq[0].due);
                void'(exq.pop_front());
            end
        end
    end

    initial begin
        model_clear();
        do_reset();

        for (int c = 0; c < 100; c++) step(1'b1, 16'sd0, 16'sd0, 2'd0);
        drain(8);

        do_reset();
        step(1'b1, 16'sd16384, 16'sd0, 2'd0);
        for (int c = 0; c < 47; c++) step(1'b1, 16'sd0, 16'sd0, 2'd0);
        drain(8);

        for (int c = 0; c < 96; c++)
            step(c % 2 == 0, 16'($urandom), 16'($urandom), 2'd1);
        drain(8);

        for (int c = 0; c < 96; c++)
            step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 2'(c / 32));
        drain(8);

        for (int c = 0; c < 60; c++) step(1'b1, 16'sh7fff, 16'sh7fff, 2'd0);
        for (int c = 0; c < 60; c++) step(1'b1, 16'sh8000, 16'sh8000, 2'd0);
        drain(8);

        for (int c = 0; c < 80; c++) begin
            logic [1:0] ph;
            ph = (c < 20) ? 2'd0 : (c < 40) ? 2'd2 : (c < 60) ? 2'd3 : 2'd0;
            step(1'b1, 16'($urandom), 16'($urandom), ph);
        end
        drain(8);

        for (int c = 0; c < 8; c++) step(1'b1, 16'($urandom), 16'($urandom), 2'd1);
        for (int c = 0; c < 10; c++) begin
            if (pend && cyc == pend_edge + 2) break;
            step(1'b1, 16'($urandom), 16'($urandom), 2'd1);
        end
        check("reached_mac2", cyc, pend_edge + 2);
        rst_n    = 1'b0;
        valid_in = 1'b0;
        model_clear();
        #1;
        check("async_rst_valid_out", valid_out, 0);
        check("async_rst_i_out", i_out, 0);
        check("async_rst_q_out", q_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) step(1'b1, 16'($urandom), 16'($urandom), 2'd0);
        drain(12);

        check("queue_drained", exq.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/rrc_matched_filter.md
# rrc_matched_filter

Receive-side root-raised-cosine matched filter and 4:1 decimator, the receive counterpart of the transmit RRC interpolator. It accepts I/Q samples at 4 samples/symbol, filters with the same 44-tap RRC prototype from `rrc_pkg`, and emits one I/Q symbol per 4 accepted samples at a selectable sampling phase. Computation is time-multiplexed over 4 cycles per symbol: one polyphase branch per cycle, 11 MACs per rail.

## Interface
- `ACC_W`, default 48: accumulator width in bits; must be ≥ 38.
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `valid_in`  in  1  sample strobe, at most one sample per cycle; no backpressure
- `i_in`  in  16  signed Q1.15 in-phase sample
- `q_in`  in  16  signed Q1.15 quadrature sample
- `sym_phase`  in  2  which sample (mod 4) of each symbol period triggers a symbol computation
- `valid_out`  out  1  one-cycle pulse per output symbol
- `i_out`  out  16  signed Q1.15 filtered in-phase symbol
- `q_out`  out  16  signed Q1.15 filtered quadrature symbol

## Operation
- Sample window: 44-entry I/Q shift register `win[0..43]`, with `win[0]` the newest sample.
  - Shifts only on `valid_in`.
  - Reset value is 0.
- Sample counter `cnt` (2 bits):
  - Increments (wrapping) on each `valid_in`.
  - Decimation strobe `dec = valid_in && (cnt == sym_phase)`.
- Snapshot: on `dec`, the post-shift window (including the current sample) is copied into snapshot registers `snap[0..43]`.
  - The live window keeps shifting independently.
- FSM states: `IDLE`, `MAC0`, `MAC1`, `MAC2`, `MAC3`.
  - `dec` in any state → `MAC0`, with the accumulators cleared.
  - `MACp` → `MACp+1`.
  - `MAC3` → `IDLE`, unless `dec` occurs in the same cycle.
- In `MACp`, for each rail: `partial = Σ_{k=0..10} snap[4k+p] * get_coeff(p,k)`, then `acc <= acc + partial`.
- Width rules:
  - 16×18 → 34-bit products, sign-extended to `ACC_W`.
  - Rounding: add 2^15, then arithmetic shift right by 16.
  - Saturate to [-32768, 32767].
- Output: in `MAC3`, `i_out`/`q_out <= sat(round(acc + partial))` and `valid_out <= 1`. Otherwise `valid_out <= 0`.
  - `i_out`/`q_out` hold their last value between pulses.
- Restart: a `dec` arriving while in `MAC0..MAC2` abandons the in-flight symbol (no `valid_out` for it) and restarts at `MAC0` on the new snapshot.
  - This can only happen when `sym_phase` changes mid-stream.
  - `dec` during `MAC3` still outputs the finishing symbol and starts the new one.
- `sym_phase` is sampled every cycle, with no synchronisation. Changing it shortens or lengthens exactly one symbol period, to between 1 and 7 samples.

## Timing
- Reset values: `valid_out` = 0, `i_out` = 0, `q_out` = 0.
  - Window, snapshot, `cnt`, and accumulators are all 0; FSM is in `IDLE`.
  - Asynchronous reset mid-computation discards everything; the first `dec` after reset behaves as from power-up.
- Latency: if the `dec` sample is accepted at clock edge E0, `valid_out` is high in the cycle after edge E4, with `i_out`/`q_out` valid alongside it.
- Throughput:
  - With continuous `valid_in`, `valid_out` pulses exactly every 4 cycles.
  - With gapped input, one pulse per 4 accepted samples.
  - Gaps never stall or corrupt an in-flight computation, because the snapshot isolates it.
- `cnt` and the window do not reset on `dec`; only `rst_n` clears them.

## Structure
- `rrc_pkg` additions:
  - `NUM_TAPS = 4*SUB_FILTER_TAPS`
  - `DECIM = 4`
  - A shared `round_sat16(acc)` function, reused by the transmit filter.
- `rrc_pkg` already provides `get_coeff(phase,k)` and `SUB_FILTER_TAPS`; the coefficient mapping is `h[4k+p] = get_coeff(p,k)`.
- One sub-module, `rrc_mac_lane`: a combinational 11-tap dot product for one rail given phase `p`. It is instantiated twice, for I and Q.

## Test plan
- Reset / zero input: 100 zero samples on continuous `valid_in` with `sym_phase=0` → `valid_out` every 4th cycle, all outputs 0; after reset all outputs are 0.
- Impulse: a single sample of `i_in=16384` then zeros, `q_in=0`, `sym_phase=0` → the 11 consecutive `i_out` values equal `round_sat16(16384*h[4j])` for j=0..10 (bit-exact against a golden model built from `get_coeff`); `q_out` stays 0.
- Latency and gaps: `valid_in` toggling 1,0,1,0 → one `valid_out` per 4 accepted samples; each pulse comes 4 edges after its `dec` sample; values are bit-exact to the golden model.
- Saturation: constant input of 32767 on both rails → outputs clamp to 32767 whenever the golden unsaturated result exceeds 32767. Constant input of -32768 → outputs clamp to -32768, with no wraparound.
- Phase change: `sym_phase` changes 0→2 mid-stream with continuous input → one symbol period is 6 samples. Changing 3→0 causes one restart (a missing pulse), after which the output spacing returns to 4 cycles and matches the golden model at the new phase.
- Reset mid-MAC: assert `rst_n=0` while in `MAC2` → outputs are 0 immediately and no stale `valid_out` appears. The next symbol is computed on a window that is zero except for the new samples.
